vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_tick_divider.sv | 34 +++
 rtl/vga_sync_gen.sv | 76 +++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants shared with downstream address generators.
// Horizontal values are pixel ticks per line; vertical values are ticks per frame, not lines.
package vga_timing_pkg;

  localparam int unsigned HSync       = 96;
  localparam int unsigned HBackPorch  = 48;
  localparam int unsigned HVisible    = 640;
  localparam int unsigned HFrontPorch = 16;
  localparam int unsigned HTotal      = 800;

  localparam int unsigned VSyncTicks    = 1600;
  localparam int unsigned VDispStart    = 24800;
  localparam int unsigned VVisibleTicks = 384000;
  localparam int unsigned VTotalTicks   = 416800;

  localparam int unsigned HVisStart = HSync + HBackPorch;
  localparam int unsigned HVisEnd   = HVisStart + HVisible;
  localparam int unsigned VVisEnd   = VDispStart + VVisibleTicks;

  localparam int unsigned HPixW = 10;
  localparam int unsigned VPixW = 19;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic active;
  } sync_t;

  function automatic sync_t decode_sync(input logic [HPixW-1:0] h, input logic [VPixW-1:0] v);
    sync_t s;
    s.hsync_n = (h >= HPixW'(HSync));
    s.vsync_n = (v >= VPixW'(VSyncTicks));
    s.active  = (h >= HPixW'(HVisStart)) && (h < HPixW'(HVisEnd)) &&
                (v >= VPixW'(VDispStart)) && (v < VPixW'(VVisEnd));
    return s;
  endfunction

endpackage

// File: rtl/vga_tick_divider.sv
// Pixel-clock prescaler: registered one-clk tick every CLK_DIV clks (constant high for 1).
module vga_tick_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            tick_d, tick_q;

  // Tick is raised on the same edge the count wraps back to 0.
  always_comb begin
    tick_d = (cnt_q == CntMax);
    cnt_d  = tick_d ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: line/frame tick counters with registered sync and window decode.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned H_TOTAL       = HTotal,
  parameter int unsigned V_TOTAL_TICKS = VTotalTicks
) (
  input  logic             clk,
  input  logic             reset,
  output logic [HPixW-1:0] HPIXEL,
  output logic [VPixW-1:0] VPIXEL,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             pixel_tick,
  output logic             display_active,
  output logic             frame_start
);

  localparam logic [HPixW-1:0] HMax = HPixW'(H_TOTAL - 1);
  localparam logic [VPixW-1:0] VMax = VPixW'(V_TOTAL_TICKS - 1);

  logic             tick;
  logic [HPixW-1:0] h_d, h_q;
  logic [VPixW-1:0] v_d, v_q;
  sync_t            sync_d;
  logic             hsync_q, vsync_q, active_q;
  logic             frame_start_d, frame_start_q;

  vga_tick_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = (h_q == HMax) ? '0 : h_q + HPixW'(1);
      v_d = (v_q == VMax) ? '0 : v_q + VPixW'(1);
    end
    // Decode the next counter values so the registered flags line up with the counters.
    sync_d        = decode_sync(h_d, v_d);
    frame_start_d = tick && (v_q == VMax);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= sync_d.hsync_n;
      vsync_q       <= sync_d.vsync_n;
      active_q      <= sync_d.active;
      frame_start_q <= frame_start_d;
    end
  end

  assign HPIXEL         = h_q;
  assign VPIXEL         = v_q;
  assign HSYNC          = hsync_q;
  assign VSYNC          = vsync_q;
  assign pixel_tick     = tick;
  assign display_active = active_q;
  assign frame_start    = frame_start_q;

endmodule
